twiddle_gen_seq: RTL and testbench
==================================

Name: twiddle_gen_seq

Overview:
- Parametrised successor to the fixed twiddle-factor ROM.
- Stores a loadable quarter-wave sine table in IEEE754 single precision and rebuilds full complex twiddles W_N^k = cos(2πk/N) − j·sin(2πk/N) by quadrant symmetry.
- Two access modes: direct indexed lookup, or an autonomous per-stage sequence for a radix-2 DIF butterfly stage.
- Sits between FFT control and the butterfly multiplier; output uses a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, IEEE754 word width; MSB is the sign bit.
- LOG2N, 6, log2 of FFT size N; legal range 3..12.
- TBL_AW, LOG2N-1, table address width; covers entries 0..N/4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_ena  in  1  table write strobe.
- wr_addr  in  TBL_AW  table entry j, 0..N/4.
- wr_data  in  DATA_WIDTH  value of sin(2πj/N).
- rd_req  in  1  direct lookup request.
- rd_idx  in  LOG2N-1  twiddle index k, 0..N/2-1.
- rd_ack  out  1  direct request accepted this cycle.
- start  in  1  begin a stage sequence.
- stage  in  4  stage s.
- busy  out  1  sequencer active.
- done  out  1  one-cycle pulse after the last twiddle of a sequence is consumed.
- err  out  1  one-cycle pulse when a write or start is rejected.
- out_valid  out  1  twiddle available.
- out_ready  in  1  consumer accepts the twiddle.
- out_re  out  DATA_WIDTH  cos term.
- out_im  out  DATA_WIDTH  −sin term.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, pipeline emptied. Table contents are not reset and are retained.
- Table: Q[0..N/4] register array with one write port and two combinational read ports. A write takes effect on the next edge.
- Writes are accepted only when busy=0. Otherwise the write is dropped and err pulses.
- Twiddle map: q = k[LOG2N-2] selects the quadrant; r = k mod N/4.
  - q=0: sin=Q[r], cos=Q[N/4−r].
  - q=1: sin=Q[N/4−r], cos=−Q[r].
  - out_im = −sin.
- Negation is a sign-bit XOR. If exponent and mantissa are both zero, the result is forced to +0 (0x00000000).
- Pipeline, two stages:
  - S1 registers the table reads and the quadrant flag.
  - S2 applies sign handling and registers out_re, out_im and out_valid.
  - Latency is 2 cycles from acceptance to out_valid when not stalled.
- Stall: when out_valid=1 and out_ready=0, the whole pipeline and sequencer hold. Outputs stay bit-stable; nothing is lost or duplicated.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: on start with stage < LOG2N, go to RUN, set j=0, busy=1. If stage >= LOG2N, ignore the start and pulse err.
  - RUN: each non-stalled cycle issues k = j<<stage, for j = 0..N/2^(stage+1)−1. After the last issue, go to DRAIN.
  - DRAIN: wait until the last twiddle is handshaken. Then pulse done, set busy=0, return to IDLE.
- Direct mode: rd_ack = rd_req & IDLE & !stall & !start. Each acknowledged request produces one output.
- Simultaneous start and rd_req: start wins and rd_ack=0.
- Direct results already in the pipeline when a start arrives drain ahead of the sequence outputs, in order.
- Reset mid-RUN aborts immediately. No done pulse; the next start runs normally.

Decomposition:
- Package twiddle_pkg holds:
  - FP32_SIGN_BIT
  - fp_neg function (sign flip with the +0 rule)
  - the FSM state typedef
  - the stage width constant
- One sub-module, twiddle_qtable: the quarter-wave register array with 1 write and 2 read ports.
- Sequencer, quadrant mapping and pipeline stay in the top level.

Test Plan:
All scenarios use LOG2N=6 (N=64, N/4=16). Load Q[j] = sin(2πj/64), so Q[0]=0x00000000, Q[8]=0x3F3504F3, Q[16]=0x3F800000.
1. Direct k=0, out_ready=1 → 2 cycles later out_re=0x3F800000, out_im=0x00000000 (never 0x80000000).
2. Direct k=16 → out_re=0x00000000, out_im=0xBF800000. Direct k=8 → 0x3F3504F3 / 0xBF3504F3. Direct k=24 → 0xBF3504F3 / 0xBF3504F3.
3. start, stage=0 → 32 twiddles for k=0..31 in order; done pulses once after the 32nd handshake.
4. start, stage=5 → exactly one twiddle (k=0), then done. start with stage=6 → err pulse, busy stays 0.
5. Hold out_ready=0 for 5 cycles mid-sequence at stage=1 → outputs held stable. Sequence resumes with no loss or duplication; 16 total outputs.
6. Cases:
   - wr_ena during RUN → err pulse, table unchanged.
   - start and rd_req in the same cycle → rd_ack=0.
   - rst mid-RUN → out_valid=0, busy=0, table retained; a following start produces correct values.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle generator: FP32 sign handling,
// sequencer state type and the stage field width.
package twiddle_pkg;

  localparam int unsigned FP32_W        = 32;
  localparam int unsigned FP32_SIGN_BIT = 31;
  localparam int unsigned STAGE_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // Sign flip; a zero magnitude always comes out as +0 so no -0 reaches the multiplier.
  function automatic logic [FP32_W-1:0] fp_neg(input logic [FP32_W-1:0] x);
    logic [FP32_W-1:0] r;
    if (x[FP32_SIGN_BIT-1:0] == '0) r = '0;
    else r = {~x[FP32_SIGN_BIT], x[FP32_SIGN_BIT-1:0]};
    return r;
  endfunction

endpackage

// File: rtl/twiddle_qtable.sv
// Quarter-wave sine table: DEPTH register entries, one write port, two
// combinational read ports. Contents are deliberately not reset.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_data write port;
//        i_rd_addr_a/o_rd_data_a and i_rd_addr_b/o_rd_data_b read ports.
module twiddle_qtable
  import twiddle_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FP32_W,
  parameter int unsigned AW         = 5,
  parameter int unsigned DEPTH      = 17
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr_a,
  output logic [DATA_WIDTH-1:0] o_rd_data_a,
  input  logic [AW-1:0]         i_rd_addr_b,
  output logic [DATA_WIDTH-1:0] o_rd_data_b
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Writes beyond the last entry are ignored.
  always_ff @(posedge clk) begin
    if (i_wr_en && (32'(i_wr_addr) < DEPTH)) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data_a = r_mem[i_rd_addr_a];
  assign o_rd_data_b = r_mem[i_rd_addr_b];

endmodule

// File: rtl/twiddle_gen_seq.sv
// Twiddle generator W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) rebuilt from a
// loadable quarter-wave table, with direct lookup and a radix-2 DIF stage
// sequencer feeding a 2-stage valid/ready pipeline.
// Ports: clk, rst (async high); wr_ena/wr_addr/wr_data table load;
//        rd_req/rd_idx/rd_ack direct lookup; start/stage/busy/done sequencer;
//        err reject pulse; out_valid/out_ready/out_re/out_im twiddle output.
module twiddle_gen_seq
  import twiddle_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2N      = 6,
  parameter int unsigned TBL_AW     = LOG2N - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_ena,
  input  logic [TBL_AW-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic [LOG2N-2:0]      rd_idx,
  output logic                  rd_ack,
  input  logic                  start,
  input  logic [STAGE_W-1:0]    stage,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im
);

  localparam int unsigned KW   = LOG2N - 1;
  localparam int unsigned QTR  = 1 << (LOG2N - 2);
  localparam int unsigned HALF = 1 << (LOG2N - 1);

  seq_state_e            r_state, w_state_nxt;
  logic [KW-1:0]         r_j, w_j_nxt;
  logic [STAGE_W-1:0]    r_stage, w_stage_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_seq_issue;

  logic                  r_s1_valid, r_s1_quad;
  logic [DATA_WIDTH-1:0] r_s1_a, r_s1_b;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_re, r_out_im;

  logic                  w_stall, w_fire, w_rd_ack, w_issue, w_quad;
  logic [KW-1:0]         w_k, w_k_seq, w_j_last;
  logic [KW-2:0]         w_r;
  logic [TBL_AW-1:0]     w_addr_a, w_addr_b;
  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;

  // A held output freezes the whole pipeline and the sequencer.
  assign w_stall  = r_out_valid & ~out_ready;
  assign w_fire   = r_out_valid & out_ready;
  assign w_rd_ack = rd_req & (r_state == ST_IDLE) & ~w_stall & ~start;

  assign w_k_seq  = r_j << r_stage;
  assign w_j_last = KW'((HALF >> r_stage) - 32'd1);
  assign w_issue  = w_seq_issue | w_rd_ack;
  assign w_k      = w_seq_issue ? w_k_seq : rd_idx;

  // Port A reads Q[r], port B reads Q[N/4-r]; quadrant picks roles in S2.
  assign w_quad   = w_k[KW-1];
  assign w_r      = w_k[KW-2:0];
  assign w_addr_a = TBL_AW'(w_r);
  assign w_addr_b = TBL_AW'(QTR) - TBL_AW'(w_r);

  twiddle_qtable #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (TBL_AW),
    .DEPTH      (QTR + 1)
  ) u_qtable (
    .clk         (clk),
    .i_wr_en     (wr_ena & (r_state == ST_IDLE)),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_rd_addr_a (w_addr_a),
    .o_rd_data_a (w_rd_a),
    .i_rd_addr_b (w_addr_b),
    .o_rd_data_b (w_rd_b)
  );

  // Sequencer next-state and pulse logic.
  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_stage_nxt = r_stage;
    w_seq_issue = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = wr_ena & (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (stage < STAGE_W'(LOG2N)) begin
            w_state_nxt = ST_RUN;
            w_j_nxt     = '0;
            w_stage_nxt = stage;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!w_stall) begin
          w_seq_issue = 1'b1;
          if (r_j == w_j_last) w_state_nxt = ST_DRAIN;
          else w_j_nxt = r_j + KW'(1);
        end
      end
      ST_DRAIN: begin
        // Last twiddle is the one leaving S2 with nothing behind it.
        if (w_fire && !r_s1_valid) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_j     <= '0;
      r_stage <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_stage <= w_stage_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // S1 captures table reads; S2 applies quadrant signs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_quad   <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else if (!w_stall) begin
      r_s1_valid  <= w_issue;
      r_s1_quad   <= w_quad;
      r_s1_a      <= w_rd_a;
      r_s1_b      <= w_rd_b;
      r_out_valid <= r_s1_valid;
      r_out_re    <= r_s1_quad ? fp_neg(r_s1_a) : r_s1_b;
      r_out_im    <= r_s1_quad ? fp_neg(r_s1_b) : fp_neg(r_s1_a);
    end
  end

  assign rd_ack    = w_rd_ack;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;

endmodule

// File: tb/tb_twiddle_gen_seq.sv
// Self-checking bench for twiddle_gen_seq (N=64). Expected twiddles come from
// real-valued cos/sin rounded to FP32; a queue tracks accepted indices in order.
module tb_twiddle_gen_seq;

  localparam real PI = 3.14159265358979323846;

  logic        clk, rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [4:0]  rd_idx;
  logic        rd_ack;
  logic        start;
  logic [3:0]  stage;
  logic        busy, done, err;
  logic        out_valid, out_ready;
  logic [31:0] out_re, out_im;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_hs  = 0;
  int          exp_q[$];
  logic [31:0] mdl_q[17];
  logic        hold_pend = 1'b0;
  logic [31:0] h_re, h_im;
  int          cmp_k;

  twiddle_gen_seq #(.DATA_WIDTH(32), .LOG2N(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_ack    (rd_ack),
    .start     (start),
    .stage     (stage),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // Round a real to FP32 via a 2^-24 grid (exact for |x| <= 1), zero is +0.
  function automatic logic [31:0] f32(input real x);
    real ax;
    int a, p, m;
    logic [31:0] r;
    ax = (x < 0.0) ? -x : x;
    a  = $rtoi(ax * 16777216.0 + 0.5);
    r  = '0;
    if (a != 0) begin
      p = 0;
      for (int i = 0; i < 26; i++) if (a[i]) p = i;
      m = (p >= 23) ? (a >>> (p - 23)) : (a << (23 - p));
      r = {x < 0.0, 8'(p + 103), m[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_re(input int k);
    return f32($cos(2.0 * PI * real'(k) / 64.0));
  endfunction

  function automatic logic [31:0] exp_im(input int k);
    return f32(-$sin(2.0 * PI * real'(k) / 64.0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Output checker: every handshake against the queue; held outputs must not move.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_re", out_re, h_re);
        chk("hold_im", out_im, h_im);
      end
      hold_pend = out_valid && !out_ready;
      h_re = out_re;
      h_im = out_im;
      if (out_valid && out_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got re=0x%08h im=0x%08h, required none", out_re, out_im);
        end else begin
          cmp_k = exp_q.pop_front();
          chk("twiddle_re", out_re, exp_re(cmp_k));
          chk("twiddle_im", out_im, exp_im(cmp_k));
        end
      end
    end
  end

  task automatic issue_direct(input int k);
    @(posedge clk); #1;
    rd_req = 1'b1;
    rd_idx = 5'(k);
    @(negedge clk);
    chk("rd_ack_idle", 32'(rd_ack), 32'd1);
    exp_q.push_back(k);
  endtask

  task automatic direct_lit(input int k, input logic [31:0] re, input logic [31:0] im);
    issue_direct(k);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("direct_valid", 32'(out_valid), 32'd1);
    chk("direct_re", out_re, re);
    chk("direct_im", out_im, im);
  endtask

  task automatic run_seq(input int s, input int stall_at, input int wr_at, input bit with_rd);
    int n0, nexp, ndone, post;
    @(posedge clk); #1;
    start  = 1'b1;
    stage  = 4'(s);
    rd_req = with_rd;
    rd_idx = 5'd3;
    @(negedge clk);
    if (with_rd) chk("rd_ack_vs_start", 32'(rd_ack), 32'd0);
    @(posedge clk); #1;
    start  = 1'b0;
    rd_req = 1'b0;
    for (int j = 0; j < (32 >> s); j++) exp_q.push_back(j << s);
    nexp  = exp_q.size();
    n0    = n_hs;
    ndone = 0;
    post  = 0;
    for (int c = 0; c < 400 && post < 4; c++) begin
      out_ready = !(stall_at > 0 && c >= stall_at && c < stall_at + 5);
      wr_ena    = (wr_at > 0 && c == wr_at);
      wr_addr   = 5'd8;
      wr_data   = 32'hDEADBEEF;
      @(negedge clk);
      if (c == 0) chk("busy_run", 32'(busy), 32'd1);
      if (wr_at > 0 && c == wr_at + 1) chk("err_wr_busy", 32'(err), 32'd1);
      if (done) begin
        ndone++;
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("outputs_per_seq", 32'(n_hs - n0), 32'(nexp));
        chk("queue_at_done", 32'(exp_q.size()), 32'd0);
      end
      if (ndone > 0) post++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wr_ena    = 1'b0;
    chk("done_pulses", 32'(ndone), 32'd1);
  endtask

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_idx = '0; start = 1'b0; stage = '0; out_ready = 1'b1;
    for (int j = 0; j < 17; j++) mdl_q[j] = f32($sin(2.0 * PI * real'(j) / 64.0));

    // Pin the model to hand-computed table words.
    chk("model_q0", mdl_q[0], 32'h00000000);
    chk("model_q8", mdl_q[8], 32'h3F3504F3);
    chk("model_q16", mdl_q[16], 32'h3F800000);
    chk("model_re24", exp_re(24), 32'hBF3504F3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_re", out_re, 32'd0);
    chk("rst_out_im", out_im, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int j = 0; j < 17; j++) begin
      @(posedge clk); #1;
      wr_ena = 1'b1; wr_addr = 5'(j); wr_data = mdl_q[j];
    end
    @(posedge clk); #1;
    wr_ena = 1'b0;
    @(negedge clk);
    chk("err_idle_write", 32'(err), 32'd0);

    direct_lit(0,  32'h3F800000, 32'h00000000);
    direct_lit(16, 32'h00000000, 32'hBF800000);
    direct_lit(8,  32'h3F3504F3, 32'hBF3504F3);
    direct_lit(24, 32'hBF3504F3, 32'hBF3504F3);

    // Direct result in flight drains ahead of the sequence.
    issue_direct(20);
    run_seq(4, 0, 0, 1'b0);

    run_seq(0, 0, 0, 1'b0);
    run_seq(5, 0, 0, 1'b0);

    // Out-of-range stage is rejected.
    @(posedge clk); #1;
    start = 1'b1; stage = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_bad_stage", 32'(err), 32'd1);
    chk("busy_bad_stage", 32'(busy), 32'd0);
    @(negedge clk);
    chk("err_pulse_len", 32'(err), 32'd0);
    chk("valid_bad_stage", 32'(out_valid), 32'd0);

    run_seq(1, 4, 0, 1'b0);
    run_seq(0, 0, 3, 1'b0);
    run_seq(5, 0, 0, 1'b1);

    // Reset aborts a running sequence.
    @(posedge clk); #1;
    start = 1'b1; stage = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 32; j++) exp_q.push_back(j);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_seq(2, 0, 0, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
